addsub_sched: RTL

Round-robin scheduler sharing one `addsub` datapath among up to NREQ requesters. Each requester offers an opcode and two operands, receives a one-cycle grant, and later receives a one-cycle done pulse alongside the result. The block drives the `addsub` input ports and captures its output after a fixed latency. One operation is in flight at a time.

---
 rtl/addsub_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/addsub_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the addsub scheduler.
package addsub_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: priority starts at ptr+1 and wraps modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);
  int c;

  // Walk from farthest to nearest so the nearest requester after ptr wins last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    c     = 0;
    for (int i = NREQ; i >= 1; i--) begin
      c = (int'(ptr_i) + i) % NREQ;
      if (req_i[IW'(c)]) begin
        gnt_o = NREQ'(1) << IW'(c);
        idx_o = IW'(c);
      end
    end
  end
endmodule

// File: rtl/addsub_sched.sv
// Round-robin scheduler sharing one external addsub datapath; one operation in flight.
module addsub_sched
  import addsub_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = 1
) (
  input  logic                  iCLK,
  input  logic                  iRSTn,
  input  logic [NREQ-1:0]       iREQ,
  input  logic [NREQ-1:0]       iOPCODE,
  input  logic [NREQ*WIDTH-1:0] iDATAIN1,
  input  logic [NREQ*WIDTH-1:0] iDATAIN2,
  output logic [NREQ-1:0]       oGNT,
  output logic [NREQ-1:0]       oDONE,
  output logic [WIDTH-1:0]      oRESULT,
  output logic                  oBUSY,
  output logic                  oAS_OPCODE,
  output logic [WIDTH-1:0]      oAS_DATAIN1,
  output logic [WIDTH-1:0]      oAS_DATAIN2,
  input  logic [WIDTH-1:0]      iAS_DATAOUT
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LAT + 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic [WIDTH-1:0]  res_q, res_d, d1_q, d1_d, d2_q, d2_d;
  logic              op_q, op_d;

  logic [NREQ-1:0]   win_oh;
  logic [IW-1:0]     win_idx;
  logic              capture, grant;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i (iREQ),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    res_d   = res_q;
    op_d    = op_q;
    d1_d    = d1_q;
    d2_d    = d2_q;

    capture = (state_q == BUSY) && (cnt_q == '0);
    grant   = (|iREQ) && ((state_q == IDLE) || capture);

    if ((state_q == BUSY) && (cnt_q != '0)) cnt_d = cnt_q - CW'(1);

    if (capture) begin
      res_d   = iAS_DATAOUT;
      done_d  = NREQ'(1) << owner_q;
      state_d = IDLE;
    end

    // A grant on the capture edge overrides the return to IDLE (back-to-back issue).
    if (grant) begin
      state_d = BUSY;
      owner_d = win_idx;
      ptr_d   = win_idx;
      cnt_d   = CW'(LAT);
      gnt_d   = win_oh;
      op_d    = iOPCODE[win_idx];
      d1_d    = iDATAIN1[win_idx*WIDTH +: WIDTH];
      d2_d    = iDATAIN2[win_idx*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      op_q    <= op_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  assign oGNT        = gnt_q;
  assign oDONE       = done_q;
  assign oRESULT     = res_q;
  assign oBUSY       = (state_q == BUSY);
  assign oAS_OPCODE  = op_q;
  assign oAS_DATAIN1 = d1_q;
  assign oAS_DATAIN2 = d2_q;
endmodule
